bus_rr_arbiter: RTL

- Shares one device-side bus port among NrHosts hosts (core instruction, core data, test utility host) using the Ibex req/gnt/rvalid protocol.
- Performs round-robin arbitration and holds the selection steady while the device stalls.
- Tracks outstanding transactions in an in-order ID FIFO so each response is routed back to the host that issued the request.
- Sits between the hosts and a single shared device, such as the RAM, in the simulation top levels.

---
 rtl/bus_rr_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts hosts.
// Latency: request and response paths are zero-cycle combinational; outstanding_o lags by one clock.
// Backpressure: device stalls latch the selection until granted; a full ID FIFO holds dev_req_o low.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   host_req_i/host_gnt_o   per-host request and grant
//   host_addr_i, host_we_i, host_be_i, host_wdata_i
//                           per-host request fields, packed with host h at slice h
//   host_rvalid_o/host_err_o
//                           per-host response strobe and error
//   host_rdata_o            read data broadcast to every host
//   dev_*                   single device-side port driven by the selected host
//   outstanding_o           registered count of transactions awaiting a response
//   unexpected_rsp_o        sticky: a response arrived with nothing outstanding
module bus_rr_arbiter #(
    parameter int NrHosts        = 3,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddrWidth-1:0]      host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,

    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddrWidth-1:0]              dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,

    output logic [$clog2(MaxOutstanding):0]   outstanding_o,
    output logic                              unexpected_rsp_o
);

    localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrW = $clog2(MaxOutstanding);
    localparam int CntW = PtrW + 1;
    localparam int BeW  = DataWidth / 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IdxW-1:0] rr_ptr;     // last granted host; search starts just after it
    logic            lock;       // device stalled a request, selection frozen
    logic [IdxW-1:0] lock_idx;   // host frozen while lock is set

    logic [IdxW-1:0] id_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [IdxW-1:0] arb_idx;
    logic            arb_found;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] sel;
    logic            fifo_full;
    logic            fifo_empty;
    logic            grant;
    logic            push;
    logic            pop;
    logic [IdxW-1:0] head;

    assign fifo_full  = (count == CntW'(MaxOutstanding));
    assign fifo_empty = (count == '0);
    assign head       = id_mem[rd_ptr];

    // Round-robin search: walk hosts starting one past rr_ptr, wrapping at
    // NrHosts-1, and take the first one requesting.
    always_comb begin
        arb_idx   = rr_ptr;
        arb_found = 1'b0;
        cand      = rr_ptr;
        for (int i = 0; i < NrHosts; i++) begin
            cand = (cand == IdxW'(NrHosts - 1)) ? '0 : cand + IdxW'(1);
            if (!arb_found && host_req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // A stalled request keeps its host so the device sees stable fields.
    assign sel = lock ? lock_idx : arb_idx;

    assign dev_req_o = (lock | (|host_req_i)) & ~fifo_full;
    assign grant     = dev_req_o & dev_gnt_i;
    assign push      = grant;
    assign pop       = dev_rvalid_i & ~fifo_empty;

    // Request field mux from the selected host.
    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (sel == IdxW'(h)) begin
                dev_addr_o  = host_addr_i[h*AddrWidth +: AddrWidth];
                dev_we_o    = host_we_i[h];
                dev_be_o    = host_be_i[h*BeW +: BeW];
                dev_wdata_o = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
    end

    // Grant and response demux; only one host bit can match sel / head.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = grant & (sel == IdxW'(h));
            host_rvalid_o[h] = pop & (head == IdxW'(h));
            host_err_o[h]    = pop & dev_err_i & (head == IdxW'(h));
        end
    end

    assign host_rdata_o  = dev_rdata_i;
    assign outstanding_o = count;

    // ------------------------------------------------------------------
    // Arbitration state: rr pointer and stall lock
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= IdxW'(NrHosts - 1);
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (grant) begin
                rr_ptr <= sel;
            end
            // While the FIFO is full dev_req_o is low, so neither branch
            // fires and an existing lock is retained.
            if (dev_req_o && !dev_gnt_i) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end else if (grant) begin
                lock <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-ID FIFO: pointers, occupancy, sticky unexpected flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            unexpected_rsp_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
            if (dev_rvalid_i && fifo_empty) begin
                unexpected_rsp_o <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= sel;
        end
    end

endmodule
